vx_wb_arbiter: RTL and testbench
================================

VX_WB_ARBITER -- requirements
Module: vx_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 5, number of execute-unit commit channels (ALU, LSU, CSR, FPU, GPU).
REQ-002 SHALL have parameter NUM_THREADS, default 4, lanes per warp.
REQ-003 SHALL have parameter NW_BITS, default 2, warp-id width.
REQ-004 SHALL have parameter NR_BITS, default 6, register-index width.
REQ-005 SHALL have parameter UUID_BITS, default 44, instruction uuid width.
REQ-006 SHALL have parameter CTR_BITS, default 44, performance counter width.
REQ-007 SHALL have parameter LOCK_EOP, default 1; when 1, a granted multi-beat packet holds the grant until its eop beat.
REQ-008 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-009 reset  in  1  reset, synchronous, active-high.
REQ-010 req_valid  in  NUM_REQS  per-channel commit valid.
REQ-011 req_ready  out  NUM_REQS  per-channel commit accept.
REQ-012 req_uuid  in  NUM_REQS*UUID_BITS  per-channel uuid.
REQ-013 req_wid  in  NUM_REQS*NW_BITS  per-channel warp id.
REQ-014 req_PC  in  NUM_REQS*32  per-channel PC.
REQ-015 req_tmask  in  NUM_REQS*NUM_THREADS  per-channel thread mask.
REQ-016 req_wb  in  NUM_REQS  per-channel register-write flag.
REQ-017 req_rd  in  NUM_REQS*NR_BITS  per-channel destination register.
REQ-018 req_data  in  NUM_REQS*NUM_THREADS*32  per-channel lane results.
REQ-019 req_eop  in  NUM_REQS  per-channel end-of-packet flag.
REQ-020 wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop  out  widths as per channel  registered writeback beat to scoreboard and register file; no back-pressure.
REQ-021 commit_count  out  CTR_BITS  committed instructions; thread_count  out  CTR_BITS  committed active lanes.

Function
REQ-022 A channel with req_valid=1 and req_wb=0 SHALL see req_ready=1 in the same cycle and be consumed with no output beat.
REQ-023 Among channels with req_valid=1 and req_wb=1, at most one SHALL be granted per cycle; only the granted channel sees req_ready=1.
REQ-024 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQS; last_grant updates on every wb=1 grant.
REQ-025 Grant SHALL be combinational from current inputs and state; req_ready SHALL not depend on any output.
REQ-026 A granted beat SHALL appear on wb_* exactly one cycle later with wb_valid=1; wb_valid SHALL be 0 in any cycle following no grant.
REQ-027 wb_* payload SHALL hold its last value when wb_valid=0 (only wb_valid is cleared).
REQ-028 LOCK_EOP=1: granting a beat with eop=0 SHALL enter state LOCKED(ch); in LOCKED only ch is grantable; the eop=1 beat from ch returns state to IDLE.
REQ-029 In LOCKED, wb=0 consumption on other channels (REQ-022) SHALL continue.
REQ-030 LOCK_EOP=0: state SHALL remain IDLE; every beat is arbitrated independently.
REQ-031 commit_count SHALL increment by 1 and thread_count by popcount(tmask) on every consumed beat with eop=1, wb=0 or wb=1, summed when several occur in one cycle.
REQ-032 Counters SHALL wrap modulo 2^CTR_BITS without saturation.

Reset
REQ-033 On reset: wb_valid=0, wb_* payload=0, state=IDLE, last_grant=NUM_REQS-1 (channel 0 highest priority), commit_count=0, thread_count=0.
REQ-034 Reset asserted mid-packet SHALL drop the lock; no beat granted in the reset cycle appears on wb_*.
REQ-035 During reset, req_ready SHALL be all zeros.

Verification
REQ-036 Channels 0,2 valid wb=1 eop=1 after reset -> cycle1 wb_valid=1 with ch0 payload, cycle2 ch2 payload, req_ready one-hot each cycle.
REQ-037 All 5 channels held valid wb=1 eop=1 for 10 cycles -> grant order 0,1,2,3,4,0,1,2,3,4; commit_count=10.
REQ-038 LOCK_EOP=1, ch1 sends 3 beats eop=0,0,1 while ch3 valid -> ch3 granted only after ch1 eop beat; output order 1,1,1,3.
REQ-039 ch4 valid wb=0 eop=1 tmask=4'b1011 -> req_ready[4]=1 same cycle, wb_valid stays 0, commit_count+1, thread_count+3.
REQ-040 Reset asserted after first of 3 locked beats on ch2 -> wb_valid=0 next cycle, state IDLE, ch0 wins next arbitration, counters 0.
REQ-041 Preload commit_count=2^CTR_BITS-1 via forced state, one eop commit -> commit_count wraps to 0.

Source files
------------

// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter
// Merges the commit streams of the execute units into a single registered
// writeback beat stream, and counts committed instructions and active lanes.
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   req_valid/req_ready : per-channel commit handshake (NUM_REQS bits)
//   req_uuid/wid/PC/tmask/wb/rd/data/eop : per-channel flattened payload,
//                         channel c occupies slice [c*W +: W]
//   wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop :
//                         registered writeback beat, no back-pressure
//   commit_count        : committed instructions (eop beats), wraps
//   thread_count        : committed active lanes, wraps
//
// Channels that do not write a register (req_wb=0) are always accepted and
// produce no beat. Register-writing channels are round-robin arbitrated; with
// LOCK_EOP=1 a multi-beat packet keeps the grant until its eop beat.
module vx_wb_arbiter #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 6,
    parameter int UUID_BITS   = 44,
    parameter int CTR_BITS    = 44,
    parameter int LOCK_EOP    = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    output logic [NUM_REQS-1:0]               req_ready,
    input  logic [NUM_REQS*UUID_BITS-1:0]     req_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]       req_wid,
    input  logic [NUM_REQS*32-1:0]            req_PC,
    input  logic [NUM_REQS*NUM_THREADS-1:0]   req_tmask,
    input  logic [NUM_REQS-1:0]               req_wb,
    input  logic [NUM_REQS*NR_BITS-1:0]       req_rd,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
    input  logic [NUM_REQS-1:0]               req_eop,
    output logic                              wb_valid,
    output logic [UUID_BITS-1:0]              wb_uuid,
    output logic [NW_BITS-1:0]                wb_wid,
    output logic [31:0]                       wb_PC,
    output logic [NUM_THREADS-1:0]            wb_tmask,
    output logic [NR_BITS-1:0]                wb_rd,
    output logic [NUM_THREADS*32-1:0]         wb_data,
    output logic                              wb_eop,
    output logic [CTR_BITS-1:0]               commit_count,
    output logic [CTR_BITS-1:0]               thread_count
);

    localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int DATA_W = NUM_THREADS * 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic logic [CTR_BITS-1:0] popcount(input logic [NUM_THREADS-1:0] mask);
        logic [CTR_BITS-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cnt = cnt + CTR_BITS'(mask[i]);
        end
        return cnt;
    endfunction

    state_e                 state_q;
    logic [IDX_W-1:0]       lock_ch_q;
    logic [IDX_W-1:0]       last_grant_q;

    logic                   wb_valid_q;
    logic [UUID_BITS-1:0]   wb_uuid_q;
    logic [NW_BITS-1:0]     wb_wid_q;
    logic [31:0]            wb_pc_q;
    logic [NUM_THREADS-1:0] wb_tmask_q;
    logic [NR_BITS-1:0]     wb_rd_q;
    logic [DATA_W-1:0]      wb_data_q;
    logic                   wb_eop_q;
    logic [CTR_BITS-1:0]    commit_q;
    logic [CTR_BITS-1:0]    thread_q;

    logic [NUM_REQS-1:0]    cand_s;
    logic [NUM_REQS-1:0]    nowb_s;
    logic [NUM_REQS-1:0]    grant_oh_s;
    logic                   grant_valid_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [IDX_W-1:0]       idx_s;
    logic [CTR_BITS-1:0]    commit_add_s;
    logic [CTR_BITS-1:0]    thread_add_s;

    // Candidate set: register-writing channels, narrowed to the lock owner mid-packet.
    always_comb begin
        nowb_s = req_valid & ~req_wb;
        cand_s = req_valid & req_wb;
        if (state_q == ST_LOCKED) begin
            cand_s = cand_s & (NUM_REQS'(1) << lock_ch_q);
        end else begin
            cand_s = cand_s;
        end
    end

    // Round-robin pick: first candidate after the last granted channel.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        idx_s         = '0;
        for (int i = 1; i <= NUM_REQS; i++) begin
            idx_s = IDX_W'((int'(last_grant_q) + i) % NUM_REQS);
            if (!grant_valid_s && cand_s[idx_s]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = idx_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        // Nothing is accepted while reset is held.
        grant_valid_s = grant_valid_s & ~reset;
    end

    // Accept: every non-writing channel plus the single granted channel.
    always_comb begin
        if (grant_valid_s) begin
            grant_oh_s = NUM_REQS'(1) << grant_idx_s;
        end else begin
            grant_oh_s = '0;
        end
        if (reset) begin
            req_ready = '0;
        end else begin
            req_ready = nowb_s | grant_oh_s;
        end
    end

    // Per-cycle counter increments, summed over all eop beats consumed this cycle.
    always_comb begin
        commit_add_s = '0;
        thread_add_s = '0;
        for (int c = 0; c < NUM_REQS; c++) begin
            if (req_valid[c] && req_ready[c] && req_eop[c]) begin
                commit_add_s = commit_add_s + CTR_BITS'(1);
                thread_add_s = thread_add_s + popcount(req_tmask[c*NUM_THREADS +: NUM_THREADS]);
            end else begin
                commit_add_s = commit_add_s;
            end
        end
    end

    // Arbitration state: lock owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lock_ch_q    <= '0;
            last_grant_q <= LAST_IDX;
        end else if (grant_valid_s) begin
            last_grant_q <= grant_idx_s;
            if ((LOCK_EOP != 0) && !req_eop[grant_idx_s]) begin
                state_q   <= ST_LOCKED;
                lock_ch_q <= grant_idx_s;
            end else begin
                state_q   <= ST_IDLE;
                lock_ch_q <= lock_ch_q;
            end
        end else begin
            state_q      <= state_q;
            lock_ch_q    <= lock_ch_q;
            last_grant_q <= last_grant_q;
        end
    end

    // Writeback register; payload only loads on a grant so it holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_uuid_q  <= '0;
            wb_wid_q   <= '0;
            wb_pc_q    <= '0;
            wb_tmask_q <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_eop_q   <= 1'b0;
        end else begin
            wb_valid_q <= grant_valid_s;
            if (grant_valid_s) begin
                wb_uuid_q  <= req_uuid[int'(grant_idx_s)*UUID_BITS +: UUID_BITS];
                wb_wid_q   <= req_wid[int'(grant_idx_s)*NW_BITS +: NW_BITS];
                wb_pc_q    <= req_PC[int'(grant_idx_s)*32 +: 32];
                wb_tmask_q <= req_tmask[int'(grant_idx_s)*NUM_THREADS +: NUM_THREADS];
                wb_rd_q    <= req_rd[int'(grant_idx_s)*NR_BITS +: NR_BITS];
                wb_data_q  <= req_data[int'(grant_idx_s)*DATA_W +: DATA_W];
                wb_eop_q   <= req_eop[grant_idx_s];
            end else begin
                wb_uuid_q  <= wb_uuid_q;
                wb_wid_q   <= wb_wid_q;
                wb_pc_q    <= wb_pc_q;
                wb_tmask_q <= wb_tmask_q;
                wb_rd_q    <= wb_rd_q;
                wb_data_q  <= wb_data_q;
                wb_eop_q   <= wb_eop_q;
            end
        end
    end

    // Performance counters, wrapping modulo 2^CTR_BITS.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_q <= '0;
            thread_q <= '0;
        end else begin
            commit_q <= commit_q + commit_add_s;
            thread_q <= thread_q + thread_add_s;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_uuid      = wb_uuid_q;
    assign wb_wid       = wb_wid_q;
    assign wb_PC        = wb_pc_q;
    assign wb_tmask     = wb_tmask_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_eop       = wb_eop_q;
    assign commit_count = commit_q;
    assign thread_count = thread_q;

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Bench for vx_wb_arbiter: directed scenarios plus a randomized run, checked
// against a reference model. Each driven cycle pushes the expected writeback
// register contents into a queue; a monitor pops and compares one per cycle.
module tb_vx_wb_arbiter;

    localparam int N  = 5;
    localparam int T  = 4;
    localparam int NW = 2;
    localparam int NR = 6;
    localparam int UB = 44;
    localparam int CB = 8;
    localparam int PW = UB + NW + 32 + T + NR + T*32 + 1;

    logic                clk;
    logic                reset;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*UB-1:0]     req_uuid;
    logic [N*NW-1:0]     req_wid;
    logic [N*32-1:0]     req_PC;
    logic [N*T-1:0]      req_tmask;
    logic [N-1:0]        req_wb;
    logic [N*NR-1:0]     req_rd;
    logic [N*T*32-1:0]   req_data;
    logic [N-1:0]        req_eop;
    logic                wb_valid;
    logic [UB-1:0]       wb_uuid;
    logic [NW-1:0]       wb_wid;
    logic [31:0]         wb_PC;
    logic [T-1:0]        wb_tmask;
    logic [NR-1:0]       wb_rd;
    logic [T*32-1:0]     wb_data;
    logic                wb_eop;
    logic [CB-1:0]       commit_count;
    logic [CB-1:0]       thread_count;

    vx_wb_arbiter #(
        .NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW), .NR_BITS(NR),
        .UUID_BITS(UB), .CTR_BITS(CB), .LOCK_EOP(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_uuid(req_uuid), .req_wid(req_wid), .req_PC(req_PC),
        .req_tmask(req_tmask), .req_wb(req_wb), .req_rd(req_rd),
        .req_data(req_data), .req_eop(req_eop),
        .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_PC(wb_PC),
        .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
        .commit_count(commit_count), .thread_count(thread_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // reference model state
    int             m_last;
    bit             m_locked;
    int             m_lock_ch;
    logic [CB-1:0]  m_commit;
    logic [CB-1:0]  m_thread;
    logic [PW-1:0]  m_last_p;
    bit             ctr_known = 1'b0;

    logic           exp_v_q[$];
    logic [PW-1:0]  exp_p_q[$];

    function automatic logic [PW-1:0] chan_payload(input int c);
        return {req_uuid[c*UB +: UB], req_wid[c*NW +: NW], req_PC[c*32 +: 32],
                req_tmask[c*T +: T], req_rd[c*NR +: NR], req_data[c*T*32 +: T*32],
                req_eop[c]};
    endfunction

    // One clock cycle: check counters, drive inputs, predict ready and the next beat.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [N-1:0] e, input logic rst, input int tm4);
        logic [N-1:0] exp_ready;
        int best;
        int bestd;
        int d;
        @(negedge clk);
        if (ctr_known) begin
            total++;
            if (commit_count !== m_commit) begin
                bad++;
                $display("FAIL commit_count: got %0d expected %0d", commit_count, m_commit);
            end
            total++;
            if (thread_count !== m_thread) begin
                bad++;
                $display("FAIL thread_count: got %0d expected %0d", thread_count, m_thread);
            end
        end
        reset     = rst;
        req_valid = v;
        req_wb    = w;
        req_eop   = e;
        for (int c = 0; c < N; c++) begin
            req_uuid[c*UB +: UB]  = UB'({$urandom(), $urandom()});
            req_wid[c*NW +: NW]   = NW'($urandom());
            req_PC[c*32 +: 32]    = $urandom();
            req_tmask[c*T +: T]   = T'($urandom());
            req_rd[c*NR +: NR]    = NR'($urandom());
            for (int k = 0; k < T; k++) begin
                req_data[(c*T+k)*32 +: 32] = $urandom();
            end
        end
        if (tm4 >= 0) begin
            req_tmask[4*T +: T] = T'(tm4);
        end
        #1;
        exp_ready = '0;
        if (rst) begin
            m_last    = N - 1;
            m_locked  = 1'b0;
            m_lock_ch = 0;
            m_commit  = '0;
            m_thread  = '0;
            m_last_p  = '0;
            exp_v_q.push_back(1'b0);
            exp_p_q.push_back('0);
        end else begin
            best  = -1;
            bestd = N;
            for (int c = 0; c < N; c++) begin
                if (v[c] && !w[c]) begin
                    exp_ready[c] = 1'b1;
                    if (e[c]) begin
                        m_commit = m_commit + CB'(1);
                        m_thread = m_thread + CB'($countones(req_tmask[c*T +: T]));
                    end
                end else if (v[c] && w[c] && (!m_locked || c == m_lock_ch)) begin
                    // distance after the last grant; smallest wins
                    d = (c - m_last - 1 + 2*N) % N;
                    if (d < bestd) begin
                        bestd = d;
                        best  = c;
                    end
                end
            end
            if (best >= 0) begin
                exp_ready[best] = 1'b1;
                if (e[best]) begin
                    m_commit = m_commit + CB'(1);
                    m_thread = m_thread + CB'($countones(req_tmask[best*T +: T]));
                end
                m_last    = best;
                m_locked  = !e[best];
                m_lock_ch = best;
                m_last_p  = chan_payload(best);
                exp_v_q.push_back(1'b1);
                exp_p_q.push_back(m_last_p);
            end else begin
                exp_v_q.push_back(1'b0);
                exp_p_q.push_back(m_last_p);
            end
        end
        total++;
        if (req_ready !== exp_ready) begin
            bad++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
        end
        ctr_known = 1'b1;
    endtask

    // Monitor: compare the writeback register against the oldest prediction.
    always @(negedge clk) begin : mon
        logic          ev;
        logic [PW-1:0] ep;
        logic [PW-1:0] ap;
        if (exp_v_q.size() > 0) begin
            ev = exp_v_q.pop_front();
            ep = exp_p_q.pop_front();
            ap = {wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop};
            total++;
            if (wb_valid !== ev || ap !== ep) begin
                bad++;
                $display("FAIL wb_beat: got valid=%b payload=%h expected valid=%b payload=%h",
                         wb_valid, ap, ev, ep);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_wb    = '0;
        req_eop   = '0;
        req_uuid  = '0;
        req_wid   = '0;
        req_PC    = '0;
        req_tmask = '0;
        req_rd    = '0;
        req_data  = '0;

        // reset state, then channels 0 and 2 competing
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b1, -1);
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b1, -1);
        cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, -1);
        cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, -1);
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0, -1);

        // all five channels for ten cycles: rotation 0..4 twice
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b1, -1);
        repeat (10) cyc(5'b11111, 5'b11111, 5'b11111, 1'b0, -1);
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0, -1);
        total++;
        if (commit_count !== CB'(10)) begin
            bad++;
            $display("FAIL commit_after_rotation: got %0d expected 10", commit_count);
        end

        // locked packet on ch1 holds off ch3
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b1, -1);
        cyc(5'b01010, 5'b01010, 5'b00000, 1'b0, -1);
        cyc(5'b01010, 5'b01010, 5'b00000, 1'b0, -1);
        cyc(5'b01010, 5'b01010, 5'b00010, 1'b0, -1);
        cyc(5'b01000, 5'b01000, 5'b01000, 1'b0, -1);

        // no-writeback commit on ch4, alone and alongside a locked packet
        cyc(5'b10000, 5'b00000, 5'b10000, 1'b0, 11);
        cyc(5'b00001, 5'b00001, 5'b00000, 1'b0, -1);
        cyc(5'b10101, 5'b00101, 5'b10000, 1'b0, 11);
        cyc(5'b00101, 5'b00101, 5'b00001, 1'b0, -1);

        // reset in the middle of a locked packet on ch2
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b1, -1);
        cyc(5'b00100, 5'b00100, 5'b00000, 1'b0, -1);
        cyc(5'b00101, 5'b00101, 5'b00000, 1'b1, -1);
        cyc(5'b00101, 5'b00101, 5'b00101, 1'b0, -1);
        cyc(5'b00100, 5'b00100, 5'b00100, 1'b0, -1);

        // counter wrap: 255 commits then one more
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b1, -1);
        repeat (51) cyc(5'b11111, 5'b00000, 5'b11111, 1'b0, -1);
        cyc(5'b00001, 5'b00000, 5'b00001, 1'b0, -1);
        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0, -1);
        total++;
        if (commit_count !== CB'(0)) begin
            bad++;
            $display("FAIL commit_wrap: got %0d expected 0", commit_count);
        end

        // randomized traffic with occasional reset
        repeat (400) begin
            cyc(N'($urandom()), N'($urandom()), N'($urandom()),
                ($urandom_range(0, 39) == 0), -1);
        end

        cyc(5'b00000, 5'b00000, 5'b00000, 1'b0, -1);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
